tick_bcd_timer: RTL and testbench
=================================

# tick_bcd_timer

Two-digit BCD seconds timer driven by the slow divided clock from the frequency divider. The divided clock enters as an ordinary data input and is synchronised into the system clock domain. Its rising edges are converted to single-cycle ticks that advance a 00..WRAP counter under start/stop/clear control. The block sits directly downstream of the divider and upstream of the board's two seven-segment digits.

## Interface
- `SYNC_STAGES`, default 2: synchroniser flops on `tick_in`; legal values 2..3.
- `WRAP_TENS`, default 5: tens value at which `x9` wraps to `00`; legal values 0..9.
- `clk` in 1: system clock, rising edge only.
- `rst` in 1: reset, asynchronous and active-high; one clock domain, no other reset.
- `tick_in` in 1: divided clock from the divider; asynchronous to `clk`.
- `start` in 1: single-cycle pulse that enters or resumes RUN.
- `stop` in 1: single-cycle pulse that pauses.
- `clear` in 1: single-cycle pulse that zeroes the count and goes to IDLE.
- `ones` out 4: BCD ones digit, registered.
- `tens` out 4: BCD tens digit, registered.
- `wrap` out 1: one-cycle pulse, registered, asserted with the `WRAP_TENS`9→00 update.
- `running` out 1: high in RUN, registered.
- `seg_ones` out 7: segments for `ones`, active-low, bit order gfedcba.
- `seg_tens` out 7: segments for `tens`, active-low, bit order gfedcba.

## Operation
- **Reset values.** `ones`=0, `tens`=0, `wrap`=0, `running`=0, state IDLE. All synchroniser and edge-history flops are 0. Segment outputs show "0" (7'b1000000).
- **Synchroniser.** A `SYNC_STAGES` flop chain on `tick_in`.
  - A history flop holds the previous synchronised value.
  - `tick_pulse` = sync_out & ~history, one `clk` cycle per rising edge of `tick_in`.
  - Falling edges are ignored.
- **FSM states.** IDLE, RUN, PAUSE.
  - IDLE --start--> RUN.
  - RUN --stop--> PAUSE.
  - PAUSE --start--> RUN.
  - Any state --clear--> IDLE.
  - `start` in RUN and `stop` in IDLE/PAUSE: no effect.
- **Priority in one cycle.** `clear` > `stop` > `start`.
- **Increment condition.** The counter increments only when the state is RUN, `tick_pulse`=1, and `stop`=0 and `clear`=0 in that cycle. A tick coincident with `stop` is lost. A tick coincident with `start` in PAUSE or IDLE is not counted.
- **Counting rules.**
  - If `ones`<9: `ones`+1.
  - If `ones`=9 and `tens`<`WRAP_TENS`: `ones`=0, `tens`+1.
  - If `ones`=9 and `tens`=`WRAP_TENS`: both become 0 and `wrap`=1 for that one cycle.
  - Digits never leave 0..9.
- **Clear.** Zeroes `ones`/`tens` on the next edge in any state and suppresses `wrap`.
- **Segment decode.** Combinational from the registered digits. Any value above 9 decodes to blank (7'b1111111), which is unreachable but defined.
- **Edge at reset release.** If `tick_in` is high at reset release, one `tick_pulse` is produced after synchronisation. The state is IDLE, so it is not counted.

## Timing
- **Edge-to-count latency.** Call E0 the first `clk` edge that samples `tick_in`=1. `ones`/`tens`/`wrap` change on edge E(`SYNC_STAGES`), i.e. E2 for the default.
- **Control latency.**
  - `start`/`stop`/`clear` sampled at edge N change the state and `running` at edge N.
  - `clear` sampled at edge N zeroes the digits at edge N.
- **`tick_in` pulse widths.** High and low must each last ≥ `SYNC_STAGES`+1 `clk` cycles. Shorter pulses may be missed; this is not an error.
- **Mid-operation reset.** `rst` asserted at any time forces all reset values immediately, without waiting for a clock edge. After release the block is in IDLE and needs `start` to count.
- **Control timing.** Control pulses need no gap. Back-to-back `stop`,`start` gives RUN again after two cycles with no tick loss except one coincident with `stop`.

## Structure
- **Shared package `timer_pkg`.**
  - State encoding: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2.
  - BCD width 4.
  - The seven-segment constants SEG_0..SEG_9 and SEG_BLANK.
- **Sub-module `bcd_to_seg7`.** Purely combinational, 4-bit BCD in, 7-bit active-low segments out. Instantiated twice.
- **Top contains** the synchroniser, edge detector, FSM and BCD counter.

## Test plan
- **Reset, then ticks without start.** Apply `rst`=1, release, apply 5 `tick_in` edges with no `start` → `ones`=0, `tens`=0, `running`=0, `seg_ones`=7'b1000000.
- **Latency and increment.** `start`, then one `tick_in` rise → `ones` becomes 1 exactly 2 edges (default) after the first sampling edge, and `running`=1.
- **Carry and wrap.** `start`, then 59 ticks → `tens`=5, `ones`=9. The 60th tick → `tens`=0, `ones`=0, and `wrap` is high for exactly 1 cycle.
- **Pause and resume.** `start`, 3 ticks, `stop`, 4 ticks, `start`, 2 ticks → count=05. A tick pulse coincident with `stop` is not counted (count stays 03).
- **Clear priority.** In RUN at count 12, assert `clear`, `stop` and `start` in the same cycle → next edge gives count 00, IDLE, `running`=0.
- **Asynchronous reset mid-count.** At count 37 assert `rst` mid-cycle → digits are 0 before the next `clk` edge. After release the block stays in IDLE until `start`.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and constants for the two-digit BCD seconds timer.
package timer_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    // Active-low segment patterns, bit order gfedcba.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low seven-segment decoder (gfedcba).
module bcd_to_seg7
    import timer_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [6:0]       seg
);

    // Non-BCD codes blank the digit.
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/tick_bcd_timer.sv
// Two-digit BCD seconds timer: synchronises the divided clock, turns its
// rising edges into ticks and counts them 00..WRAP_TENS9 under
// start/stop/clear control. Control pulses are single-cycle, sampled on the
// rising clk edge; no handshake, every pulse is accepted in the cycle it is
// high. dbg_state exposes the FSM state for checkers.
module tick_bcd_timer
    import timer_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int WRAP_TENS   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_in,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    output logic [BCD_W-1:0] ones,
    output logic [BCD_W-1:0] tens,
    output logic             wrap,
    output logic             running,
    output logic [6:0]       seg_ones,
    output logic [6:0]       seg_tens,
    output logic [1:0]       dbg_state
);

    localparam logic [BCD_W-1:0] WRAP_T = BCD_W'(WRAP_TENS);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   sync_out;
    logic                   tick_pulse;

    state_e                 state_q, state_d;
    logic                   running_q, running_d;
    logic [BCD_W-1:0]       ones_q, ones_d;
    logic [BCD_W-1:0]       tens_q, tens_d;
    logic                   wrap_q, wrap_d;
    logic                   inc;

    assign sync_out   = sync_q[SYNC_STAGES-1];
    assign tick_pulse = sync_out & ~hist_q;

    // Synchroniser chain plus edge history flop for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tick_in};
            hist_q <= sync_out;
        end
    end

    // Next-state logic: clear beats stop beats start.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else if (stop) begin
            if (state_q == ST_RUN) state_d = ST_PAUSE;
        end else if (start) begin
            if (state_q != ST_RUN) state_d = ST_RUN;
        end
        running_d = (state_d == ST_RUN);
    end

    // Counter next value; a tick sharing its cycle with stop or clear is dropped.
    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        wrap_d = 1'b0;
        inc    = (state_q == ST_RUN) && tick_pulse && !stop && !clear;
        if (clear) begin
            ones_d = '0;
            tens_d = '0;
        end else if (inc) begin
            if (ones_q != 4'd9) begin
                ones_d = ones_q + 4'd1;
            end else if (tens_q != WRAP_T) begin
                ones_d = '0;
                tens_d = tens_q + 4'd1;
            end else begin
                ones_d = '0;
                tens_d = '0;
                wrap_d = 1'b1;
            end
        end
    end

    // State, status and digit registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
            ones_q    <= '0;
            tens_q    <= '0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= running_d;
            ones_q    <= ones_d;
            tens_q    <= tens_d;
            wrap_q    <= wrap_d;
        end
    end

    assign ones      = ones_q;
    assign tens      = tens_q;
    assign wrap      = wrap_q;
    assign running   = running_q;
    assign dbg_state = state_q;

    bcd_to_seg7 u_seg_ones (.bcd(ones_q), .seg(seg_ones));
    bcd_to_seg7 u_seg_tens (.bcd(tens_q), .seg(seg_tens));

endmodule

// File: tb/tb_tick_bcd_timer.sv
// Directed bench for tick_bcd_timer with a reference model and expected queue.
module tb_tick_bcd_timer;

  logic       clk;
  logic       rst;
  logic       tick_in;
  logic       start;
  logic       stop;
  logic       clear;
  logic [3:0] ones;
  logic [3:0] tens;
  logic       wrap;
  logic       running;
  logic [6:0] seg_ones;
  logic [6:0] seg_tens;
  logic [1:0] dbg_state;

  int n_vec  = 0;
  int n_miss = 0;

  // reference model
  logic [3:0] m_ones;
  logic [3:0] m_tens;
  logic [1:0] m_state;   // 0 idle, 1 run, 2 pause
  logic [8:0] exp_q[$];  // {wrap, tens, ones}
  logic [6:0] seg_tab [10];

  tick_bcd_timer #(.SYNC_STAGES(2), .WRAP_TENS(5)) dut (
    .clk(clk), .rst(rst), .tick_in(tick_in), .start(start), .stop(stop),
    .clear(clear), .ones(ones), .tens(tens), .wrap(wrap), .running(running),
    .seg_ones(seg_ones), .seg_tens(seg_tens), .dbg_state(dbg_state)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_running"}, 16'(running), 16'(m_state == 2'd1));
    check({tag, "_state"}, 16'(dbg_state), 16'(m_state));
    check({tag, "_digits"}, {8'h0, tens, ones}, {8'h0, m_tens, m_ones});
  endtask

  // one full tick_in period; the expected result is queued when the edge is driven
  task automatic tick(input string tag);
    logic [3:0] pre_o;
    logic [3:0] pre_t;
    logic       w;
    logic [8:0] e;
    pre_o = m_ones;
    pre_t = m_tens;
    w = 1'b0;
    @(negedge clk);
    tick_in = 1'b1;
    if (m_state == 2'd1) begin
      if (m_ones != 4'd9) m_ones = m_ones + 4'd1;
      else if (m_tens != 4'd5) begin m_ones = 4'd0; m_tens = m_tens + 4'd1; end
      else begin m_ones = 4'd0; m_tens = 4'd0; w = 1'b1; end
    end
    exp_q.push_back({w, m_tens, m_ones});
    @(posedge clk);            // E0
    @(posedge clk);            // E1
    #1;
    check({tag, "_early"}, {8'h0, tens, ones}, {8'h0, pre_t, pre_o});
    @(posedge clk);            // E2
    #1;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_miss++;
      $error("FAIL %s_queue: observed empty expected entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_count"}, {7'h0, wrap, tens, ones}, {7'h0, e});
    end
    check({tag, "_seg_ones"}, 16'(seg_ones), 16'(seg_tab[m_ones]));
    check({tag, "_seg_tens"}, 16'(seg_tens), 16'(seg_tab[m_tens]));
    check({tag, "_running"}, 16'(running), 16'(m_state == 2'd1));
    @(posedge clk);
    #1;
    check({tag, "_wrap_gone"}, 16'(wrap), 16'h0);
    @(negedge clk);
    tick_in = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic ctrl(input string tag, input logic s, input logic p, input logic c);
    @(negedge clk);
    start = s;
    stop  = p;
    clear = c;
    if (c) begin
      m_state = 2'd0;
      m_ones  = 4'd0;
      m_tens  = 4'd0;
    end else if (p) begin
      if (m_state == 2'd1) m_state = 2'd2;
    end else if (s) begin
      m_state = 2'd1;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    clear = 1'b0;
    check_status(tag);
    check({tag, "_wrap"}, 16'(wrap), 16'h0);
  endtask

  // directed sequence
  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;
    m_ones = 4'd0; m_tens = 4'd0; m_state = 2'd0;
    rst = 1'b1; tick_in = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
    #1;
    check("rst_async_digits", {8'h0, tens, ones}, 16'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_status("reset");
    check("reset_wrap", 16'(wrap), 16'h0);
    check("reset_seg_ones", 16'(seg_ones), 16'h40);
    check("reset_seg_tens", 16'(seg_tens), 16'h40);

    // ticks without start are ignored
    for (int i = 0; i < 5; i++) tick("idle_tick");
    check_status("idle_after");

    // latency, increment, carry and wrap
    ctrl("start1", 1'b1, 1'b0, 1'b0);
    tick("first_tick");
    for (int i = 0; i < 58; i++) tick("count_tick");
    check_status("at_59");
    tick("wrap_tick");
    check_status("after_wrap");

    // pause and resume
    ctrl("clear1", 1'b0, 1'b0, 1'b1);
    ctrl("start2", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick("run_tick");
    ctrl("stop1", 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) tick("paused_tick");
    ctrl("stop_in_pause", 1'b0, 1'b1, 1'b0);
    ctrl("start3", 1'b1, 1'b0, 1'b0);
    ctrl("start_in_run", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) tick("resume_tick");
    check_status("at_05");

    // tick pulse coincident with stop is lost
    @(negedge clk);
    tick_in = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    stop = 1'b1;
    m_state = 2'd2;
    @(posedge clk);
    #1;
    stop = 1'b0;
    check_status("stop_coincident");
    @(negedge clk);
    tick_in = 1'b0;
    repeat (4) @(negedge clk);
    check_status("stop_coincident_later");

    // clear wins over stop and start
    ctrl("clear2", 1'b0, 1'b0, 1'b1);
    ctrl("start4", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) tick("to12_tick");
    check_status("at_12");
    ctrl("clear_prio", 1'b1, 1'b1, 1'b1);

    // asynchronous reset mid-count
    ctrl("start5", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 37; i++) tick("to37_tick");
    check_status("at_37");
    @(posedge clk);
    #2;
    rst = 1'b1;
    m_ones = 4'd0; m_tens = 4'd0; m_state = 2'd0;
    #1;
    check_status("async_rst");
    check("async_rst_seg", 16'(seg_ones), 16'h40);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick("post_rst_idle_tick");
    check_status("post_rst_idle");
    ctrl("start6", 1'b1, 1'b0, 1'b0);
    tick("post_rst_count");

    if (exp_q.size() != 0) begin
      n_vec++;
      n_miss++;
      $error("FAIL queue_drain: observed %0d left expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
